nc_ctx_ctrl: RTL and testbench
==============================

Name: nc_ctx_ctrl

Overview:
Context manager and sequencer for CAVLC nC prediction. It stores per-4x4-block TotalCoeff for the current macroblock, the left-MB column and an up-row line buffer. It drives the packed neighbour buses consumed by nC_decoding. It sits between the residual/coeff_token decoder, which writes TotalCoeff, and nC_decoding, and advances context at every MB boundary.

Parameters:
LB_DEPTH, 128, up-row line buffer entries (max picture width in MBs); address width = `mb_x_bits.
TC_W, 5, stored TotalCoeff width; zero-extended to 8 bits on output bytes.

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
mb_start  in  1  pulse: begin new MB at mb_x_in/mb_y_in
mb_x_in  in  `mb_x_bits  MB column
mb_y_in  in  `mb_y_bits  MB row
mb_skip  in  1  qualifies mb_done: MB has no residual, store all zeros
mb_done  in  1  pulse: current MB finished, commit context
tc_wr  in  1  TotalCoeff write strobe
tc_comp  in  2  0=luma, 1=cb, 2=cr (3 ignored)
tc_idx  in  4  luma4x4BlkIdx, or chroma4x4BlkIdx in [1:0]
tc_val  in  5  TotalCoeff 0..16
ctx_ready  out  1  high while ACTIVE; neighbour buses valid
busy  out  1  high in RD/LOAD/WB
nC_up_mb  out  32  bytes 0..3 = up-MB luma blocks 10,11,14,15
nC_left_mb  out  32  bytes 0..3 = left-MB luma blocks 5,7,13,15
nC_curr_mb  out  128  byte k = current luma block k (byte 15 also updated)
nC_cb_up_mb / nC_cr_up_mb  out  16  up-MB chroma blocks 2,3
nC_cb_left_mb / nC_cr_left_mb  out  16  left-MB chroma blocks 1,3
nC_cb_curr_mb / nC_cr_curr_mb  out  32  byte k = current chroma block k

Behaviour:
- FSM: IDLE -> RD -> LOAD -> ACTIVE -> WB -> IDLE.
- IDLE: on mb_start, latch mb_x/mb_y, clear all current-MB bytes, go to RD. mb_start in any other state is ignored.
- RD: issue a synchronous line-buffer read at latched mb_x.
- LOAD: capture read data into the up registers. If mb_y==0, capture zeros instead, because line-buffer contents are undefined after reset. Then go to ACTIVE.
- Latency: ctx_ready asserts exactly 3 cycles after the mb_start cycle.
- ACTIVE: tc_wr updates the addressed current byte on the next edge. tc_wr outside ACTIVE, or with tc_comp==3, is dropped.
- mb_done in ACTIVE goes to WB. tc_wr in the same cycle as mb_done is applied and included in the commit. mb_done outside ACTIVE is ignored.
- mb_skip with mb_done: the commit uses zeros for every block regardless of stored values.
- WB (1 cycle):
  - Write bottom row (luma 10,11,14,15; cb 2,3; cr 2,3) to line buffer[mb_x], 40 bits.
  - Copy right column (luma 5,7,13,15; cb 1,3; cr 1,3) to the left registers.
  - Return to IDLE.
- Left registers are not cleared at mb_x==0. nC_decoding masks picture and slice edges.
- Output bytes: {3'b0, TC}. All registers reset to 0. The line buffer is not reset.
- Reset mid-MB: return to IDLE immediately. Partial context is discarded and no line-buffer write occurs.
- Back-to-back: mb_start may arrive in the cycle after WB (IDLE). Min MB period is 5 cycles.

Optional Feature:
NC_CHROMA_EN
- Defined: cb/cr current, left and up storage present; line-buffer entry is 40 bits.
- Undefined (4:0:0 build): no chroma storage; chroma outputs tied to 0; tc_comp 1/2 writes dropped; line-buffer entry is 20 bits.

Decomposition:
- Shared package/defines: state encodings; component codes (LUMA=0, CB=1, CR=2); bottom-row and right-column index constants; TC_W.
- One sub-module, nc_line_buf: single-port synchronous-read RAM, LB_DEPTH x 40 (or 20), 1-cycle read latency.

Test Plan:
- Reset then mb_start at (0,0) -> ctx_ready high 3 cycles later; all output buses 0.
- MB (0,0): write luma blk15=7, blk10=3, cb blk3=2, then mb_done. Next MB (1,0) -> nC_left_mb byte3=7, byte2=0, cb_left byte1=2, nC_up_mb=0.
- Row 1, MB (0,1) -> nC_up_mb bytes0..3 = row 0 MB0 blocks 10,11,14,15 (3,0,0,7).
- mb_skip with mb_done after writes of 9 -> next MB left bytes and the later up read all 0.
- tc_wr of blk15=5 in the same cycle as mb_done -> next MB nC_left_mb byte3=5. tc_wr in IDLE has no effect.
- rst asserted in ACTIVE after writes -> outputs 0 next cycle, FSM IDLE, line buffer[mb_x] unchanged.

Source files
------------

// File: rtl/nc_ctx_ctrl_pkg.sv
// Shared state/component encodings and block-index constants for the nC context controller.
// NC_CHROMA_EN selects the 4:2:0 build (cb/cr context stored, 40-bit line-buffer entries).
`ifndef MB_X_BITS
`define MB_X_BITS 7
`endif
`ifndef MB_Y_BITS
`define MB_Y_BITS 8
`endif

package nc_ctx_ctrl_pkg;

  localparam int NC_TC_W     = 5;
  localparam int NC_LB_DEPTH = 128;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RD     = 3'd1,
    ST_LOAD   = 3'd2,
    ST_ACTIVE = 3'd3,
    ST_WB     = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    COMP_LUMA = 2'd0,
    COMP_CB   = 2'd1,
    COMP_CR   = 2'd2
  } comp_e;

  // Element 0 is the lowest output byte.
  localparam logic [3:0][3:0] LUMA_BOT   = {4'd15, 4'd14, 4'd11, 4'd10};
  localparam logic [3:0][3:0] LUMA_RIGHT = {4'd15, 4'd13, 4'd7,  4'd5};

`ifdef NC_CHROMA_EN
  localparam logic [1:0][1:0] CH_BOT   = {2'd3, 2'd2};
  localparam logic [1:0][1:0] CH_RIGHT = {2'd3, 2'd1};
  localparam int LB_FIELDS = 8;
`else
  localparam int LB_FIELDS = 4;
`endif

endpackage

// File: rtl/nc_ctx_ctrl_line_buf.sv
// Up-row line buffer: single-port RAM with registered (1-cycle) read, contents not reset.
module nc_line_buf #(
  parameter int DEPTH = 128,
  parameter int WIDTH = 40,
  parameter int AW    = 7
) (
  input  logic             clk,
  input  logic             rdEn,
  input  logic             wrEn,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wrData,
  output logic [WIDTH-1:0] rdData
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wrEn) begin
      mem[addr] <= wrData;
    end else if (rdEn) begin
      rdData <= mem[addr];
    end
  end

endmodule

// File: rtl/nc_ctx_ctrl.sv
// nC context manager: holds current/left/up TotalCoeff context and drives nC_decoding buses.
// NC_CHROMA_EN adds cb/cr context; without it chroma outputs are tied to zero.
//
// state     | meaning
// ST_IDLE   | waiting for mb_start
// ST_RD     | line-buffer read issued at mbX
// ST_LOAD   | up registers capture read data (zeros on row 0)
// ST_ACTIVE | neighbour buses valid, TotalCoeff writes accepted
// ST_WB     | bottom row to line buffer, right column to left registers
module nc_ctx_ctrl
  import nc_ctx_ctrl_pkg::*;
#(
  parameter int LB_DEPTH = NC_LB_DEPTH,
  parameter int TC_W     = NC_TC_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   mb_start,
  input  logic [`MB_X_BITS-1:0]  mb_x_in,
  input  logic [`MB_Y_BITS-1:0]  mb_y_in,
  input  logic                   mb_skip,
  input  logic                   mb_done,
  input  logic                   tc_wr,
  input  logic [1:0]             tc_comp,
  input  logic [3:0]             tc_idx,
  input  logic [4:0]             tc_val,
  output logic                   ctx_ready,
  output logic                   busy,
  output logic [31:0]            nC_up_mb,
  output logic [31:0]            nC_left_mb,
  output logic [127:0]           nC_curr_mb,
  output logic [15:0]            nC_cb_up_mb,
  output logic [15:0]            nC_cr_up_mb,
  output logic [15:0]            nC_cb_left_mb,
  output logic [15:0]            nC_cr_left_mb,
  output logic [31:0]            nC_cb_curr_mb,
  output logic [31:0]            nC_cr_curr_mb
);

  localparam int LB_W = LB_FIELDS * TC_W;

  state_e stateQ, stateD;
  logic [`MB_X_BITS-1:0] mbX;
  logic [`MB_Y_BITS-1:0] mbY;
  logic                  skipQ;

  logic [TC_W-1:0] curLuma  [16];
  logic [TC_W-1:0] upLuma   [4];
  logic [TC_W-1:0] leftLuma [4];

  logic            lbRdEn, lbWrEn;
  logic [LB_W-1:0] lbWrData, lbRdData;

  logic            wrActive;
  logic [TC_W-1:0] wrVal;

  assign wrActive = (stateQ == ST_ACTIVE) && tc_wr;
  assign wrVal    = tc_val[TC_W-1:0];

  always_comb begin
    stateD    = stateQ;
    ctx_ready = 1'b0;
    busy      = 1'b0;
    lbRdEn    = 1'b0;
    lbWrEn    = 1'b0;
    case (stateQ)
      ST_IDLE: if (mb_start) stateD = ST_RD;
      ST_RD: begin
        busy   = 1'b1;
        lbRdEn = 1'b1;
        stateD = ST_LOAD;
      end
      ST_LOAD: begin
        busy   = 1'b1;
        stateD = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        ctx_ready = 1'b1;
        if (mb_done) stateD = ST_WB;
      end
      ST_WB: begin
        busy   = 1'b1;
        lbWrEn = 1'b1;
        stateD = ST_IDLE;
      end
      default: stateD = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stateQ <= ST_IDLE;
      mbX    <= '0;
      mbY    <= '0;
      skipQ  <= 1'b0;
      for (int k = 0; k < 16; k++) curLuma[k] <= '0;
      for (int i = 0; i < 4; i++) begin
        upLuma[i]   <= '0;
        leftLuma[i] <= '0;
      end
    end else begin
      stateQ <= stateD;
      case (stateQ)
        ST_IDLE: if (mb_start) begin
          mbX <= mb_x_in;
          mbY <= mb_y_in;
          for (int k = 0; k < 16; k++) curLuma[k] <= '0;
        end
        // Row 0 has no valid line-buffer data after reset
        ST_LOAD: for (int i = 0; i < 4; i++)
          upLuma[i] <= (mbY == '0) ? '0 : lbRdData[i*TC_W +: TC_W];
        ST_ACTIVE: begin
          if (wrActive && tc_comp == COMP_LUMA) curLuma[tc_idx] <= wrVal;
          if (mb_done) skipQ <= mb_skip;
        end
        ST_WB: for (int i = 0; i < 4; i++)
          leftLuma[i] <= skipQ ? '0 : curLuma[LUMA_RIGHT[i]];
        default: ;
      endcase
    end
  end

`ifdef NC_CHROMA_EN
  logic [TC_W-1:0] curCb  [4];
  logic [TC_W-1:0] curCr  [4];
  logic [TC_W-1:0] upCb   [2];
  logic [TC_W-1:0] upCr   [2];
  logic [TC_W-1:0] leftCb [2];
  logic [TC_W-1:0] leftCr [2];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 4; k++) begin
        curCb[k] <= '0;
        curCr[k] <= '0;
      end
      for (int i = 0; i < 2; i++) begin
        upCb[i]   <= '0;
        upCr[i]   <= '0;
        leftCb[i] <= '0;
        leftCr[i] <= '0;
      end
    end else begin
      case (stateQ)
        ST_IDLE: if (mb_start) begin
          for (int k = 0; k < 4; k++) begin
            curCb[k] <= '0;
            curCr[k] <= '0;
          end
        end
        ST_LOAD: for (int i = 0; i < 2; i++) begin
          upCb[i] <= (mbY == '0) ? '0 : lbRdData[(4+i)*TC_W +: TC_W];
          upCr[i] <= (mbY == '0) ? '0 : lbRdData[(6+i)*TC_W +: TC_W];
        end
        ST_ACTIVE: begin
          if (wrActive && tc_comp == COMP_CB) curCb[tc_idx[1:0]] <= wrVal;
          if (wrActive && tc_comp == COMP_CR) curCr[tc_idx[1:0]] <= wrVal;
        end
        ST_WB: for (int i = 0; i < 2; i++) begin
          leftCb[i] <= skipQ ? '0 : curCb[CH_RIGHT[i]];
          leftCr[i] <= skipQ ? '0 : curCr[CH_RIGHT[i]];
        end
        default: ;
      endcase
    end
  end

  for (genvar i = 0; i < 2; i++) begin : g_ch_nb
    assign nC_cb_up_mb[i*8 +: 8]   = 8'(upCb[i]);
    assign nC_cr_up_mb[i*8 +: 8]   = 8'(upCr[i]);
    assign nC_cb_left_mb[i*8 +: 8] = 8'(leftCb[i]);
    assign nC_cr_left_mb[i*8 +: 8] = 8'(leftCr[i]);
  end
  for (genvar k = 0; k < 4; k++) begin : g_ch_cur
    assign nC_cb_curr_mb[k*8 +: 8] = 8'(curCb[k]);
    assign nC_cr_curr_mb[k*8 +: 8] = 8'(curCr[k]);
  end
`else
  assign nC_cb_up_mb   = '0;
  assign nC_cr_up_mb   = '0;
  assign nC_cb_left_mb = '0;
  assign nC_cr_left_mb = '0;
  assign nC_cb_curr_mb = '0;
  assign nC_cr_curr_mb = '0;
`endif

  always_comb begin
    lbWrData = '0;
    for (int i = 0; i < 4; i++)
      lbWrData[i*TC_W +: TC_W] = skipQ ? '0 : curLuma[LUMA_BOT[i]];
`ifdef NC_CHROMA_EN
    for (int i = 0; i < 2; i++) begin
      lbWrData[(4+i)*TC_W +: TC_W] = skipQ ? '0 : curCb[CH_BOT[i]];
      lbWrData[(6+i)*TC_W +: TC_W] = skipQ ? '0 : curCr[CH_BOT[i]];
    end
`endif
  end

  for (genvar i = 0; i < 4; i++) begin : g_luma_nb
    assign nC_up_mb[i*8 +: 8]   = 8'(upLuma[i]);
    assign nC_left_mb[i*8 +: 8] = 8'(leftLuma[i]);
  end
  for (genvar k = 0; k < 16; k++) begin : g_luma_cur
    assign nC_curr_mb[k*8 +: 8] = 8'(curLuma[k]);
  end

  nc_line_buf #(
    .DEPTH (LB_DEPTH),
    .WIDTH (LB_W),
    .AW    (`MB_X_BITS)
  ) u_line_buf (
    .clk    (clk),
    .rdEn   (lbRdEn),
    .wrEn   (lbWrEn),
    .addr   (mbX),
    .wrData (lbWrData),
    .rdData (lbRdData)
  );

endmodule

// File: tb/tb_nc_ctx_ctrl.sv
// Randomized bench for nc_ctx_ctrl against a whole-macroblock reference model.
`ifndef MB_X_BITS
`define MB_X_BITS 7
`endif
`ifndef MB_Y_BITS
`define MB_Y_BITS 8
`endif

module tb_nc_ctx_ctrl;

`ifdef NC_CHROMA_EN
  localparam bit CHROMA_EN = 1'b1;
`else
  localparam bit CHROMA_EN = 1'b0;
`endif

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  mb_start, mb_skip, mb_done, tc_wr;
  logic [`MB_X_BITS-1:0] mb_x_in;
  logic [`MB_Y_BITS-1:0] mb_y_in;
  logic [1:0]            tc_comp;
  logic [3:0]            tc_idx;
  logic [4:0]            tc_val;
  logic                  ctx_ready, busy;
  logic [31:0]           nC_up_mb, nC_left_mb;
  logic [127:0]          nC_curr_mb;
  logic [15:0]           nC_cb_up_mb, nC_cr_up_mb, nC_cb_left_mb, nC_cr_left_mb;
  logic [31:0]           nC_cb_curr_mb, nC_cr_curr_mb;

  nc_ctx_ctrl dut (
    .clk(clk), .rst(rst), .mb_start(mb_start), .mb_x_in(mb_x_in), .mb_y_in(mb_y_in),
    .mb_skip(mb_skip), .mb_done(mb_done), .tc_wr(tc_wr), .tc_comp(tc_comp),
    .tc_idx(tc_idx), .tc_val(tc_val), .ctx_ready(ctx_ready), .busy(busy),
    .nC_up_mb(nC_up_mb), .nC_left_mb(nC_left_mb), .nC_curr_mb(nC_curr_mb),
    .nC_cb_up_mb(nC_cb_up_mb), .nC_cr_up_mb(nC_cr_up_mb),
    .nC_cb_left_mb(nC_cb_left_mb), .nC_cr_left_mb(nC_cr_left_mb),
    .nC_cb_curr_mb(nC_cb_curr_mb), .nC_cr_curr_mb(nC_cr_curr_mb)
  );

  always #5 clk = ~clk;

  // Reference model: whole macroblocks as byte arrays
  logic [15:0][7:0] mCur, mLeft;
  logic [3:0][7:0]  mCb, mCr, mLeftCb, mLeftCr;
  logic [15:0][7:0] stL  [128];
  logic [3:0][7:0]  stCb [128];
  logic [3:0][7:0]  stCr [128];
  bit               stOk [128];

  typedef struct { int comp; int idx; int val; } wr_t;
  wr_t wrQ[$];

  int nVec = 0;
  int nErr = 0;

  task automatic checkVal(input string tag, input logic [127:0] got, input logic [127:0] exp);
    nVec++;
    if (got !== exp) begin
      nErr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic addWr(input int c, input int i, input int v);
    wr_t w;
    w.comp = c; w.idx = i; w.val = v;
    wrQ.push_back(w);
  endtask

  task automatic modelWrite(input wr_t w);
    if (w.comp == 0) mCur[w.idx] = 8'(w.val);
    else if (CHROMA_EN && w.comp == 1) mCb[w.idx % 4] = 8'(w.val);
    else if (CHROMA_EN && w.comp == 2) mCr[w.idx % 4] = 8'(w.val);
  endtask

  task automatic driveWr(input wr_t w);
    tc_wr = 1'b1; tc_comp = 2'(w.comp); tc_idx = 4'(w.idx); tc_val = 5'(w.val);
  endtask

  task automatic modelReset();
    mCur = '0; mCb = '0; mCr = '0; mLeft = '0; mLeftCb = '0; mLeftCr = '0;
  endtask

  task automatic checkLeft(input string tag);
    checkVal({tag, "_left"},    128'(nC_left_mb),    128'({mLeft[15], mLeft[13], mLeft[7], mLeft[5]}));
    checkVal({tag, "_cb_left"}, 128'(nC_cb_left_mb), 128'({mLeftCb[3], mLeftCb[1]}));
    checkVal({tag, "_cr_left"}, 128'(nC_cr_left_mb), 128'({mLeftCr[3], mLeftCr[1]}));
  endtask

  task automatic checkCur(input string tag);
    checkVal({tag, "_curr"},    nC_curr_mb,          mCur);
    checkVal({tag, "_cb_curr"}, 128'(nC_cb_curr_mb), 128'(mCb));
    checkVal({tag, "_cr_curr"}, 128'(nC_cr_curr_mb), 128'(mCr));
  endtask

  task automatic doMb(input int x, input int y, input bit skip, input bit wrAtDone, input bit rstMid);
    int n;
    wr_t w;
    // stray write and mb_done in IDLE must be ignored
    tc_wr = 1'b1; tc_comp = 2'd0; tc_idx = 4'd15; tc_val = 5'd9; mb_done = 1'b1;
    tick();
    tc_wr = 1'b0; mb_done = 1'b0;
    checkVal("idle_state", 128'({ctx_ready, busy}), 128'(2'b00));
    checkVal("idle_curr", nC_curr_mb, mCur);

    mb_start = 1'b1; mb_x_in = `MB_X_BITS'(x); mb_y_in = `MB_Y_BITS'(y);
    tick();
    mCur = '0; mCb = '0; mCr = '0;
    // second mb_start and a write while in RD must be ignored
    mb_x_in = `MB_X_BITS'(x ^ 1); mb_y_in = `MB_Y_BITS'(y + 1);
    tc_wr = 1'b1; tc_comp = 2'd0; tc_idx = 4'd0; tc_val = 5'd3;
    checkVal("rd_state", 128'({ctx_ready, busy}), 128'(2'b01));
    checkVal("rd_curr", nC_curr_mb, mCur);
    tick();
    mb_start = 1'b0; tc_wr = 1'b0;
    checkVal("load_state", 128'({ctx_ready, busy}), 128'(2'b01));
    tick();
    checkVal("ready_lat3", 128'({ctx_ready, busy}), 128'(2'b10));
    checkCur("act0");
    checkLeft("act0");
    if (y == 0) begin
      checkVal("up_row0", 128'(nC_up_mb), 128'(0));
      checkVal("cb_up_row0", 128'({nC_cb_up_mb, nC_cr_up_mb}), 128'(0));
    end else if (stOk[x]) begin
      checkVal("up", 128'(nC_up_mb), 128'({stL[x][15], stL[x][14], stL[x][11], stL[x][10]}));
      checkVal("cb_up", 128'(nC_cb_up_mb), 128'({stCb[x][3], stCb[x][2]}));
      checkVal("cr_up", 128'(nC_cr_up_mb), 128'({stCr[x][3], stCr[x][2]}));
    end

    n = wrQ.size();
    for (int i = 0; i < n; i++) begin
      if (wrAtDone && !rstMid && i == n - 1) break;
      driveWr(wrQ[i]);
      tick();
      modelWrite(wrQ[i]);
    end
    tc_wr = 1'b0;
    checkCur("act_wr");

    if (rstMid) begin
      rst = 1'b1;
      #1;
      modelReset();
      checkVal("rst_state", 128'({ctx_ready, busy}), 128'(2'b00));
      checkCur("rst");
      checkLeft("rst");
      checkVal("rst_up", 128'({nC_up_mb, nC_cb_up_mb, nC_cr_up_mb}), 128'(0));
      tick();
      rst = 1'b0;
      tick();
      checkVal("post_rst_state", 128'({ctx_ready, busy}), 128'(2'b00));
    end else begin
      mb_done = 1'b1; mb_skip = skip;
      if (wrAtDone && n > 0) driveWr(wrQ[n-1]);
      tick();
      mb_done = 1'b0; mb_skip = 1'b0; tc_wr = 1'b0;
      if (wrAtDone && n > 0) begin
        w = wrQ[n-1];
        modelWrite(w);
      end
      checkVal("wb_state", 128'({ctx_ready, busy}), 128'(2'b01));
      if (skip) begin
        stL[x] = '0; stCb[x] = '0; stCr[x] = '0;
      end else begin
        stL[x] = mCur; stCb[x] = mCb; stCr[x] = mCr;
      end
      stOk[x] = 1'b1;
      mLeft = stL[x]; mLeftCb = stCb[x]; mLeftCr = stCr[x];
      tick();
      checkVal("done_state", 128'({ctx_ready, busy}), 128'(2'b00));
      checkLeft("done");
      checkCur("done");
    end
    wrQ.delete();
  endtask

  initial begin
    int cols[4];
    cols[0] = 0; cols[1] = 1; cols[2] = 2; cols[3] = 127;
    for (int i = 0; i < 128; i++) stOk[i] = 1'b0;
    modelReset();
    rst = 1'b1; mb_start = 1'b0; mb_skip = 1'b0; mb_done = 1'b0; tc_wr = 1'b0;
    mb_x_in = '0; mb_y_in = '0; tc_comp = '0; tc_idx = '0; tc_val = '0;
    repeat (3) @(posedge clk);
    #1;
    checkVal("reset_state", 128'({ctx_ready, busy}), 128'(2'b00));
    checkVal("reset_buses", 128'({nC_up_mb, nC_left_mb, nC_cb_up_mb, nC_cr_up_mb,
                                  nC_cb_left_mb, nC_cr_left_mb}), 128'(0));
    checkCur("reset");
    rst = 1'b0;
    tick();

    // MB (0,0): blk15=7, blk10=3, cb blk3=2
    addWr(0, 15, 7); addWr(0, 10, 3); addWr(1, 3, 2);
    doMb(0, 0, 1'b0, 1'b0, 1'b0);
    checkVal("tp_left_b3", 128'(nC_left_mb[31:24]), 128'(8'd7));
    checkVal("tp_cb_left_b1", 128'(nC_cb_left_mb[15:8]), 128'(CHROMA_EN ? 8'd2 : 8'd0));

    // MB (1,0): writes of 9 committed as skip
    addWr(0, 5, 9); addWr(0, 7, 9); addWr(0, 13, 9); addWr(0, 15, 9);
    addWr(0, 10, 9); addWr(0, 11, 9); addWr(0, 14, 9); addWr(1, 3, 9);
    doMb(1, 0, 1'b1, 1'b0, 1'b0);
    checkVal("tp_skip_left", 128'(nC_left_mb), 128'(0));

    // MB (2,0): blk15=5 written in the mb_done cycle
    addWr(0, 3, 1); addWr(0, 15, 5);
    doMb(2, 0, 1'b0, 1'b1, 1'b0);
    checkVal("tp_done_wr", 128'(nC_left_mb[31:24]), 128'(8'd5));

    doMb(0, 1, 1'b0, 1'b0, 1'b0);
    doMb(1, 1, 1'b0, 1'b0, 1'b0);
    // reset in ACTIVE: line buffer[2] must keep the row-0 data
    addWr(0, 10, 12); addWr(0, 15, 11);
    doMb(2, 1, 1'b0, 1'b0, 1'b1);
    doMb(2, 2, 1'b0, 1'b0, 1'b0);

    for (int y = 0; y < 5; y++) begin
      for (int c = 0; c < 4; c++) begin
        int n;
        n = $urandom_range(0, 8);
        for (int i = 0; i < n; i++)
          addWr($urandom_range(0, 3), $urandom_range(0, 15), $urandom_range(0, 16));
        doMb(cols[c], y, ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
             ($urandom_range(0, 9) == 0));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end

endmodule
